// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - 8N1 UART receiver with mid-bit sampling, frame error and break handling
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT      = 5208,
  parameter int CLK_COUNTER_WIDTH = $clog2(CLKS_PER_BIT),
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CLK_COUNTER_WIDTH-1:0] HALF_M1  = CLK_COUNTER_WIDTH'(HALF - 1);
  localparam logic [CLK_COUNTER_WIDTH-1:0] BIT_M1   = CLK_COUNTER_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]             LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  state_t                       state_q, state_d;
  logic [CLK_COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]         shift_q, shift_d;
  logic [DATA_BITS-1:0]         data_d;
  logic                         valid_d;
  logic                         err_d;
  logic                         rx_meta;
  logic                         rx_s;

  // Synchronizer flops reset to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      frame_err  <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_out;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = S_START;
      end

      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_BREAK_WAIT;
          end
        end
      end

      // A held-low line must release before another start bit is accepted.
      S_BREAK_WAIT: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - scoreboard bench for uart_rx_fsm with a 16-clock bit period
module tb_uart_rx_fsm;

  localparam int BIT  = 16;
  localparam int HALF = BIT / 2;
  localparam int LAT  = 2 + HALF + 9 * BIT + 1;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_count = 0;
  int fe_count = 0;
  logic [7:0] exp_q[$];

  uart_rx_fsm #(.CLKS_PER_BIT(BIT), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1);
  end

  // Scoreboard side: every data_valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (data_valid) begin
      dv_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: data_out=%h, expected no pulse", data_out);
      end else begin
        exp_b = exp_q.pop_front();
        if (data_out !== exp_b) begin
          n_fail++;
          $display("FAIL sb_data: data_out=%h, expected %h", data_out, exp_b);
        end
      end
    end
    if (frame_err) fe_count++;
    if (data_valid || frame_err) begin
      n_checks++;
      if (data_valid && frame_err) begin
        n_fail++;
        $display("FAIL pulse_exclusive: data_valid=%b frame_err=%b, expected not both", data_valid, frame_err);
      end
    end
  end

  // Called just after a negedge; drives one 8N1 frame, optionally with +-2 cycle edge jitter.
  task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input bit jitter,
                           input int max_cycles, input bit push);
    int elapsed;
    int prev_j;
    int j;
    int len;
    logic lvl;
    if (push) exp_q.push_back(b);
    elapsed = 0;
    prev_j  = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      lvl = 1'b0;
      else if (k == 9) lvl = stop_lvl;
      else             lvl = b[k-1];
      if (jitter && k < 9) j = int'($urandom_range(0, 4)) - 2;
      else                 j = 0;
      len    = BIT + j - prev_j;
      prev_j = j;
      rx_in  = lvl;
      for (int c = 0; c < len; c++) begin
        if (max_cycles >= 0 && elapsed >= max_cycles) return;
        @(negedge clk);
        elapsed++;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h, expected 00", data_out); end
    n_checks++;
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", data_valid); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    bit   found;
    logic busy_at;
    logic prev_busy;
    int   fe0;
    found = 0; busy_at = 1'bx; prev_busy = 1'b0;
    fe0 = fe_count;
    fork
      send_byte(8'hA5, 1'b1, 1'b0, -1, 1'b1);
      begin
        for (int c = 0; c < 400 && !found; c++) begin
          @(negedge clk);
          if (data_valid) begin found = 1; busy_at = busy; end
          else prev_busy = busy;
        end
      end
    join
    repeat (4) @(negedge clk);
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL single_pulse: no data_valid within 400 cycles, expected one"); end
    n_checks++;
    if (busy_at !== 1'b0 || prev_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_fall: busy before/at pulse=%b/%b, expected 1/0", prev_busy, busy_at);
    end
    n_checks++;
    if (data_out !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h, expected a5", data_out); end
    n_checks++;
    if (fe_count != fe0) begin n_fail++; $display("FAIL single_no_err: frame_err pulses=%0d, expected 0", fe_count - fe0); end
  endtask

  task automatic test_back_to_back();
    int dv0;
    dv0 = dv_count;
    send_byte(8'h00, 1'b1, 1'b0, -1, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b0, -1, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (dv_count - dv0 != 2) begin n_fail++; $display("FAIL b2b_count: pulses=%0d, expected 2", dv_count - dv0); end
    n_checks++;
    if (data_out !== 8'hFF) begin n_fail++; $display("FAIL b2b_last: got %h, expected ff", data_out); end
  endtask

  task automatic test_glitch();
    int dv0;
    int busy_cycles;
    dv0 = dv_count;
    busy_cycles = 0;
    rx_in = 1'b0;
    repeat (5) begin @(negedge clk); if (busy) busy_cycles++; end
    rx_in = 1'b1;
    repeat (30) begin @(negedge clk); if (busy) busy_cycles++; end
    n_checks++;
    if (busy_cycles < 1 || busy_cycles >= 10) begin
      n_fail++;
      $display("FAIL glitch_busy: busy cycles=%0d, expected 1..9", busy_cycles);
    end
    n_checks++;
    if (busy !== 1'b0 || dv_count != dv0) begin
      n_fail++;
      $display("FAIL glitch_idle: busy=%b pulses=%0d, expected 0 and 0", busy, dv_count - dv0);
    end
    send_byte(8'h3C, 1'b1, 1'b0, -1, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (data_out !== 8'h3C) begin n_fail++; $display("FAIL glitch_next: got %h, expected 3c", data_out); end
  endtask

  task automatic test_break();
    int dv0;
    int fe0;
    dv0 = dv_count;
    fe0 = fe_count;
    send_byte(8'h55, 1'b0, 1'b0, -1, 1'b0);
    repeat (40 * BIT) @(negedge clk);
    n_checks++;
    if (fe_count - fe0 != 1) begin n_fail++; $display("FAIL break_err_count: pulses=%0d, expected 1", fe_count - fe0); end
    n_checks++;
    if (dv_count != dv0) begin n_fail++; $display("FAIL break_no_valid: pulses=%0d, expected 0", dv_count - dv0); end
    n_checks++;
    if (data_out !== 8'h3C) begin n_fail++; $display("FAIL break_hold: got %h, expected 3c", data_out); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b, expected 1", busy); end
    rx_in = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL break_release: busy=%b, expected 0", busy); end
    send_byte(8'h12, 1'b1, 1'b0, -1, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (data_out !== 8'h12) begin n_fail++; $display("FAIL break_next: got %h, expected 12", data_out); end
  endtask

  task automatic test_mid_reset();
    int dv0;
    int fe0;
    send_byte(8'hC3, 1'b1, 1'b0, 5 * BIT + 6, 1'b0);
    rst   = 1'b0;
    rx_in = 1'b1;
    #1;
    n_checks++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: data_out=%h valid=%b err=%b busy=%b, expected 00 0 0 0",
               data_out, data_valid, frame_err, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    dv0 = dv_count;
    fe0 = fe_count;
    repeat (12 * BIT) @(negedge clk);
    n_checks++;
    if (dv_count != dv0 || fe_count != fe0) begin
      n_fail++;
      $display("FAIL midrst_no_pulse: valid=%0d err=%0d, expected 0 and 0", dv_count - dv0, fe_count - fe0);
    end
    send_byte(8'h81, 1'b1, 1'b0, -1, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (data_out !== 8'h81) begin n_fail++; $display("FAIL midrst_next: got %h, expected 81", data_out); end
  endtask

  task automatic test_latency_skew();
    int  cyc;
    bit  found;
    int  dv0;
    cyc = 0;
    found = 0;
    fork
      send_byte(8'h01, 1'b1, 1'b0, -1, 1'b1);
      begin
        while (!found && cyc < 400) begin
          @(negedge clk);
          cyc++;
          if (data_valid) found = 1;
        end
      end
    join
    repeat (4) @(negedge clk);
    n_checks++;
    if (!found || cyc != LAT) begin
      n_fail++;
      $display("FAIL latency: data_valid after %0d cycles (found=%0d), expected %0d", cyc, found, LAT);
    end
    dv0 = dv_count;
    send_byte(8'h6B, 1'b1, 1'b1, -1, 1'b1);
    send_byte(8'hD2, 1'b1, 1'b1, -1, 1'b1);
    send_byte(8'h3F, 1'b1, 1'b1, -1, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (dv_count - dv0 != 3) begin n_fail++; $display("FAIL skew_count: pulses=%0d, expected 3", dv_count - dv0); end
    n_checks++;
    if (data_out !== 8'h3F) begin n_fail++; $display("FAIL skew_last: got %h, expected 3f", data_out); end
  endtask

  initial begin
    rst   = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_break();
    test_mid_reset();
    test_latency_skew();
    repeat (2 * BIT) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected bytes never received, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
